data_island_receiver: RTL and testbench

DATA_ISLAND_RECEIVER -- requirements
Module: data_island_receiver

---
 rtl/hdmi_rx_pkg.sv | 68 ++++++
 rtl/terc4_decoder.sv | 23 ++
 rtl/data_island_receiver.sv | 197 +++++++++++++++++++
 tb/tb_data_island_receiver.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_rx_pkg.sv
// Shared definitions for the HDMI data island receiver: guard-band code,
// TERC4 code table, receiver state encoding and the packet container.
// Optional feature macro: PACKET_ECC_CHECK_EN (adds the BCH parity helpers).
package hdmi_rx_pkg;

  // Data island guard-band symbol carried on channels 1 and 2
  localparam logic [9:0] GUARD_BAND = 10'b0100110011;

  // TERC4 code words, indexed by the 4-bit value they carry
  localparam logic [15:0][9:0] TERC4_TABLE = {
    10'b1011000011,  // 15
    10'b0101100011,  // 14
    10'b1001110001,  // 13
    10'b1010001110,  // 12
    10'b1011000110,  // 11
    10'b0110011100,  // 10
    10'b0100111001,  // 9
    10'b1011001100,  // 8
    10'b0100111100,  // 7
    10'b0110001110,  // 6
    10'b0100011110,  // 5
    10'b0101110001,  // 4
    10'b1011100010,  // 3
    10'b1011100100,  // 2
    10'b1001100011,  // 1
    10'b1010011100   // 0
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEAD_GB,
    ST_DATA,
    ST_TRAIL_GB
  } rx_state_e;

  // One data island packet: header {ECC, HB2, HB1, HB0}, four subpackets {ECC, SB6..SB0}
  typedef struct packed {
    logic [31:0]      header;
    logic [3:0][63:0] sub;
  } packet_t;

`ifdef PACKET_ECC_CHECK_EN
  // BCH(1+x^6+x^7+x^8) parity over the first nbits of data, bit 0 first
  function automatic logic [7:0] bch_parity(input logic [55:0] data, input int nbits);
    logic [7:0] ecc;
    logic       fb;
    ecc = 8'd0;
    for (int b = 0; b < 56; b++) begin
      if (b < nbits) begin
        fb  = ecc[0] ^ data[b];
        ecc = {1'b0, ecc[7:1]} ^ (fb ? 8'h83 : 8'h00);
      end
    end
    return ecc;
  endfunction

  // Mismatch flags {sub3..sub0, header} between recomputed and received parity
  function automatic logic [4:0] packet_ecc_flags(input packet_t p);
    logic [4:0] flags;
    flags[0] = (bch_parity({32'd0, p.header[23:0]}, 24) != p.header[31:24]);
    for (int i = 0; i < 4; i++) begin
      flags[i+1] = (bch_parity(p.sub[i][55:0], 56) != p.sub[i][63:56]);
    end
    return flags;
  endfunction
`endif

endpackage

// File: rtl/terc4_decoder.sv
// TERC4 symbol decoder: maps a 10-bit channel symbol to {valid, 4-bit value}.
// Symbols outside the 16-entry code table decode as invalid with value 0.
module terc4_decoder
  import hdmi_rx_pkg::*;
(
  input  logic [9:0] symbol,
  output logic       valid,
  output logic [3:0] value
);

  // Table lookup against every TERC4 code word
  always_comb begin
    valid = 1'b0;
    value = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (symbol == TERC4_TABLE[i]) begin
        valid = 1'b1;
        value = 4'(i);
      end
    end
  end

endmodule

// File: rtl/data_island_receiver.sv
// HDMI data island receiver: tracks leading/trailing guard bands, assembles
// 32-symbol packets from the three TERC4 channels and flags island errors.
// Optional feature macro: PACKET_ECC_CHECK_EN (per-packet BCH parity check).
module data_island_receiver
  import hdmi_rx_pkg::*;
#(
  parameter int MAX_PACKETS = 18,
  parameter int GUARD_LEN   = 2
) (
  input  logic             clk_pixel,
  input  logic             reset,
  input  logic             symbol_valid,
  input  logic [2:0][9:0]  tmds_symbol,
  output logic             packet_valid,
  output logic [31:0]      header,
  output logic [3:0][63:0] sub,
  output logic [1:0]       sync_out,
  output logic [4:0]       ecc_error,
  output logic [2:0]       island_error,
  output logic [4:0]       packet_count
);

  // A guard band is complete once this many guard symbols precede the current one
  localparam logic [7:0] GB_DONE_AT = 8'(GUARD_LEN - 1);
  localparam logic [4:0] MAX_PK     = 5'(MAX_PACKETS);

  localparam int ERR_TERC4    = 0;
  localparam int ERR_TRUNC    = 1;
  localparam int ERR_OVERFLOW = 2;

  logic [2:0]       dec_valid;
  logic [2:0][3:0]  dec_value;
  logic             is_guard;

  rx_state_e        state_q, state_d;
  logic [4:0]       k_q, k_d;
  logic [7:0]       gb_cnt_q, gb_cnt_d;
  packet_t          asm_q, asm_d;
  packet_t          pkt_q, pkt_d;
  logic             packet_valid_q, packet_valid_d;
  logic [1:0]       sync_q, sync_d;
  logic [2:0]       island_err_q, island_err_d;
  logic [4:0]       count_q, count_d;

  for (genvar ch = 0; ch < 3; ch++) begin : g_dec
    terc4_decoder u_terc4_decoder (
      .symbol (tmds_symbol[ch]),
      .valid  (dec_valid[ch]),
      .value  (dec_value[ch])
    );
  end

  assign is_guard = (tmds_symbol[1] == GUARD_BAND) && (tmds_symbol[2] == GUARD_BAND) &&
                    dec_valid[0] && (dec_value[0][3:2] == 2'b11);

  // Next-state, packet assembly and error tracking; everything holds while symbol_valid is low
  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    gb_cnt_d       = gb_cnt_q;
    asm_d          = asm_q;
    pkt_d          = pkt_q;
    packet_valid_d = 1'b0;
    sync_d         = sync_q;
    island_err_d   = island_err_q;
    count_d        = count_q;

    if (symbol_valid) begin
      if (dec_valid[0] && ((state_q != ST_IDLE) || is_guard)) begin
        sync_d = dec_value[0][1:0];
      end

      case (state_q)
        ST_IDLE: begin
          if (is_guard) begin
            island_err_d = 3'd0;
            count_d      = 5'd0;
            k_d          = 5'd0;
            gb_cnt_d     = 8'd1;
            state_d      = (GUARD_LEN <= 1) ? ST_DATA : ST_LEAD_GB;
          end
        end

        ST_LEAD_GB: begin
          if (!is_guard) begin
            state_d = ST_IDLE;
          end else if (gb_cnt_q >= GB_DONE_AT) begin
            k_d     = 5'd0;
            state_d = ST_DATA;
          end else begin
            gb_cnt_d = gb_cnt_q + 8'd1;
          end
        end

        ST_DATA: begin
          if (is_guard) begin
            if (k_q != 5'd0) begin
              island_err_d[ERR_TRUNC] = 1'b1;
            end
            k_d      = 5'd0;
            gb_cnt_d = 8'd1;
            state_d  = (GUARD_LEN <= 1) ? ST_IDLE : ST_TRAIL_GB;
          end else if (!(&dec_valid)) begin
            island_err_d[ERR_TERC4] = 1'b1;
            k_d     = 5'd0;
            state_d = ST_IDLE;
          end else begin
            asm_d.header[k_q] = dec_value[0][2];
            for (int i = 0; i < 4; i++) begin
              asm_d.sub[i][{k_q, 1'b0}] = dec_value[1][i];
              asm_d.sub[i][{k_q, 1'b1}] = dec_value[2][i];
            end
            k_d = k_q + 5'd1;
            if (k_q == 5'd31) begin
              if (count_q == MAX_PK) begin
                island_err_d[ERR_OVERFLOW] = 1'b1;
                state_d = ST_IDLE;
              end else begin
                count_d        = count_q + 5'd1;
                pkt_d          = asm_d;
                packet_valid_d = 1'b1;
              end
            end
          end
        end

        ST_TRAIL_GB: begin
          if (is_guard && (gb_cnt_q < GB_DONE_AT)) begin
            gb_cnt_d = gb_cnt_q + 8'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      k_q            <= 5'd0;
      gb_cnt_q       <= 8'd0;
      asm_q          <= '0;
      pkt_q          <= '0;
      packet_valid_q <= 1'b0;
      sync_q         <= 2'd0;
      island_err_q   <= 3'd0;
      count_q        <= 5'd0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      gb_cnt_q       <= gb_cnt_d;
      asm_q          <= asm_d;
      pkt_q          <= pkt_d;
      packet_valid_q <= packet_valid_d;
      sync_q         <= sync_d;
      island_err_q   <= island_err_d;
      count_q        <= count_d;
    end
  end

`ifdef PACKET_ECC_CHECK_EN
  logic [4:0] ecc_q, ecc_d;

  // Capture the parity comparison for the packet being strobed out
  always_comb begin
    ecc_d = ecc_q;
    if (packet_valid_d) begin
      ecc_d = packet_ecc_flags(pkt_d);
    end
  end

  // ECC flag register, held until the next packet strobe
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      ecc_q <= 5'd0;
    end else begin
      ecc_q <= ecc_d;
    end
  end

  assign ecc_error = ecc_q;
`else
  assign ecc_error = 5'd0;
`endif

  assign packet_valid = packet_valid_q;
  assign header       = pkt_q.header;
  assign sub          = pkt_q.sub;
  assign sync_out     = sync_q;
  assign island_error = island_err_q;
  assign packet_count = count_q;

endmodule

// File: tb/tb_data_island_receiver.sv
// Directed testbench for data_island_receiver: guard-band framing, packet
// assembly, truncation, TERC4 errors, overflow, mid-packet reset and the
// optional PACKET_ECC_CHECK_EN parity flags.
module tb_data_island_receiver;

  localparam logic [9:0] GB    = 10'b0100110011;
  localparam logic [9:0] CTRL0 = 10'b1101010100;
  localparam logic [9:0] BAD   = 10'b1111111111;
`ifdef PACKET_ECC_CHECK_EN
  localparam logic [4:0] EXP_BAD_ECC = 5'b00001;
`else
  localparam logic [4:0] EXP_BAD_ECC = 5'b00000;
`endif

  typedef struct packed {
    logic [31:0]      header;
    logic [3:0][63:0] sub;
  } pkt_t;

  logic             clk_pixel = 1'b0;
  logic             reset;
  logic             symbol_valid;
  logic [2:0][9:0]  tmds_symbol;
  logic             packet_valid;
  logic [31:0]      header;
  logic [3:0][63:0] sub;
  logic [1:0]       sync_out;
  logic [4:0]       ecc_error;
  logic [2:0]       island_error;
  logic [4:0]       packet_count;

  int compared   = 0;
  int mismatched = 0;
  int strobes    = 0;
  int exp_strobes;

  pkt_t pa, pb, pc, pd, pe, pf, pg, ph, pbad;

  data_island_receiver dut (
    .clk_pixel    (clk_pixel),
    .reset        (reset),
    .symbol_valid (symbol_valid),
    .tmds_symbol  (tmds_symbol),
    .packet_valid (packet_valid),
    .header       (header),
    .sub          (sub),
    .sync_out     (sync_out),
    .ecc_error    (ecc_error),
    .island_error (island_error),
    .packet_count (packet_count)
  );

  always #5 clk_pixel = ~clk_pixel;

  // Count every packet strobe, sampled mid-cycle
  always @(negedge clk_pixel) begin
    if (packet_valid === 1'b1) strobes++;
  end

  function automatic logic [9:0] terc4_enc(input logic [3:0] v);
    case (v)
      4'd0:    return 10'b1010011100;
      4'd1:    return 10'b1001100011;
      4'd2:    return 10'b1011100100;
      4'd3:    return 10'b1011100010;
      4'd4:    return 10'b0101110001;
      4'd5:    return 10'b0100011110;
      4'd6:    return 10'b0110001110;
      4'd7:    return 10'b0100111100;
      4'd8:    return 10'b1011001100;
      4'd9:    return 10'b0100111001;
      4'd10:   return 10'b0110011100;
      4'd11:   return 10'b1011000110;
      4'd12:   return 10'b1010001110;
      4'd13:   return 10'b1001110001;
      4'd14:   return 10'b0101100011;
      default: return 10'b1011000011;
    endcase
  endfunction

  function automatic logic [7:0] bch8(input logic [55:0] d, input int n);
    logic [7:0] e;
    logic       fb;
    e = 8'd0;
    for (int b = 0; b < n; b++) begin
      fb = e[0] ^ d[b];
      e  = {1'b0, e[7:1]} ^ (fb ? 8'h83 : 8'h00);
    end
    return e;
  endfunction

  function automatic pkt_t make_packet(input logic [7:0] hb0, input logic [7:0] hb1,
                                       input logic [7:0] hb2, input logic [7:0] seed);
    pkt_t p;
    p.header[23:0]  = {hb2, hb1, hb0};
    p.header[31:24] = bch8({32'd0, p.header[23:0]}, 24);
    for (int i = 0; i < 4; i++) begin
      p.sub[i][55:0]  = {seed + 8'(i), 48'h5A3C_96E1_0F72 ^ {24'(i + 1) * 24'h010203, {3{seed}}}};
      p.sub[i][63:56] = bch8(p.sub[i][55:0], 56);
    end
    return p;
  endfunction

  task automatic applyStimulus(input logic [9:0] c0, input logic [9:0] c1,
                               input logic [9:0] c2, input logic valid);
    symbol_valid   = valid;
    tmds_symbol[0] = c0;
    tmds_symbol[1] = c1;
    tmds_symbol[2] = c2;
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected)
      else begin
        mismatched++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic send_guard(input logic [1:0] sync);
    applyStimulus(terc4_enc({2'b11, sync}), GB, GB, 1'b1);
  endtask

  task automatic send_ctrl();
    applyStimulus(CTRL0, CTRL0, CTRL0, 1'b1);
  endtask

  task automatic send_packet(input pkt_t p, input logic [1:0] sync,
                             input int n_sym, input int gap_at);
    logic [3:0] v1, v2;
    for (int k = 0; k < n_sym; k++) begin
      if (k == gap_at) begin
        for (int g = 0; g < 3; g++) begin
          applyStimulus(BAD, BAD, BAD, 1'b0);
          checkOutput("gap_no_strobe", 64'(packet_valid), 64'd0);
        end
      end
      for (int i = 0; i < 4; i++) begin
        v1[i] = p.sub[i][2*k];
        v2[i] = p.sub[i][2*k+1];
      end
      applyStimulus(terc4_enc({1'b1, p.header[k], sync}), terc4_enc(v1), terc4_enc(v2), 1'b1);
    end
  endtask

  initial begin
    pa   = make_packet(8'h02, 8'h00, 8'h0F, 8'h11);
    pb   = make_packet(8'h84, 8'h01, 8'h0A, 8'h22);
    pc   = make_packet(8'h82, 8'h02, 8'h0D, 8'h33);
    pd   = make_packet(8'h02, 8'h10, 8'h20, 8'h44);
    pe   = make_packet(8'h03, 8'h55, 8'hAA, 8'h55);
    pf   = make_packet(8'h0A, 8'h01, 8'h00, 8'h66);
    pg   = make_packet(8'h02, 8'hC3, 8'h3C, 8'h77);
    ph   = make_packet(8'h81, 8'h7E, 8'hE7, 8'h88);
    pbad = ph;
    pbad.header[24] = ~pbad.header[24];

    // Reset state
    reset        = 1'b1;
    symbol_valid = 1'b0;
    tmds_symbol  = '0;
    repeat (3) @(posedge clk_pixel);
    #1;
    checkOutput("rst_packet_valid", 64'(packet_valid), 64'd0);
    checkOutput("rst_header", 64'(header), 64'd0);
    checkOutput("rst_sub0", sub[0], 64'd0);
    checkOutput("rst_sub3", sub[3], 64'd0);
    checkOutput("rst_sync", 64'(sync_out), 64'd0);
    checkOutput("rst_ecc", 64'(ecc_error), 64'd0);
    checkOutput("rst_island_err", 64'(island_error), 64'd0);
    checkOutput("rst_count", 64'(packet_count), 64'd0);
    reset = 1'b0;
    send_ctrl();

    // Single audio-sample packet island
    exp_strobes = 0;
    send_guard(2'b01);
    send_guard(2'b01);
    send_packet(pa, 2'b01, 32, -1);
    exp_strobes++;
    checkOutput("one_valid", 64'(packet_valid), 64'd1);
    checkOutput("one_hb0", 64'(header[7:0]), 64'h02);
    checkOutput("one_header", 64'(header), 64'(pa.header));
    checkOutput("one_sub0", sub[0], pa.sub[0]);
    checkOutput("one_sub3", sub[3], pa.sub[3]);
    checkOutput("one_count", 64'(packet_count), 64'd1);
    checkOutput("one_island_err", 64'(island_error), 64'd0);
    checkOutput("one_ecc", 64'(ecc_error), 64'd0);
    checkOutput("one_sync", 64'(sync_out), 64'd1);
    send_guard(2'b01);
    checkOutput("one_strobe_width", 64'(packet_valid), 64'd0);
    checkOutput("one_header_hold", 64'(header), 64'(pa.header));
    send_guard(2'b01);
    send_ctrl();
    checkOutput("one_strobes", 64'(strobes), 64'(exp_strobes));

    // Two packets back to back, second one stalled by symbol_valid=0
    send_guard(2'b10);
    checkOutput("two_count_clear", 64'(packet_count), 64'd0);
    send_guard(2'b10);
    send_packet(pb, 2'b10, 32, -1);
    exp_strobes++;
    checkOutput("two_first_header", 64'(header), 64'(pb.header));
    checkOutput("two_first_sub1", sub[1], pb.sub[1]);
    send_packet(pc, 2'b10, 32, 7);
    exp_strobes++;
    checkOutput("two_second_valid", 64'(packet_valid), 64'd1);
    checkOutput("two_second_header", 64'(header), 64'(pc.header));
    checkOutput("two_second_sub2", sub[2], pc.sub[2]);
    checkOutput("two_count", 64'(packet_count), 64'd2);
    checkOutput("two_sync", 64'(sync_out), 64'd2);
    send_guard(2'b10);
    send_guard(2'b10);
    send_ctrl();
    checkOutput("two_strobes", 64'(strobes), 64'(exp_strobes));

    // Trailing guard band arriving at k=12 truncates the packet
    send_guard(2'b00);
    send_guard(2'b00);
    send_packet(pd, 2'b00, 32, -1);
    exp_strobes++;
    send_packet(pe, 2'b00, 12, -1);
    send_guard(2'b00);
    checkOutput("trunc_island_err", 64'(island_error), 64'b010);
    checkOutput("trunc_no_valid", 64'(packet_valid), 64'd0);
    checkOutput("trunc_header_hold", 64'(header), 64'(pd.header));
    checkOutput("trunc_count", 64'(packet_count), 64'd1);
    send_guard(2'b00);
    send_ctrl();
    checkOutput("trunc_strobes", 64'(strobes), 64'(exp_strobes));

    // Non-TERC4 symbol on channel 2 at k=5
    send_guard(2'b11);
    checkOutput("terc_err_clear", 64'(island_error), 64'd0);
    checkOutput("terc_count_clear", 64'(packet_count), 64'd0);
    send_guard(2'b11);
    send_packet(pf, 2'b11, 5, -1);
    applyStimulus(terc4_enc(4'b1011), terc4_enc(4'd3), BAD, 1'b1);
    checkOutput("terc_island_err", 64'(island_error), 64'b001);
    send_packet(pf, 2'b00, 32, -1);
    checkOutput("terc_idle_no_valid", 64'(packet_valid), 64'd0);
    checkOutput("terc_idle_sync_hold", 64'(sync_out), 64'd3);
    checkOutput("terc_strobes", 64'(strobes), 64'(exp_strobes));
    send_ctrl();

    // Overflow: 19 packets in an island that accepts 18
    send_guard(2'b00);
    send_guard(2'b00);
    for (int n = 0; n < 19; n++) begin
      send_packet(make_packet(8'h02, 8'(n), 8'h00, 8'(n * 7)), 2'b00, 32, -1);
    end
    exp_strobes += 18;
    checkOutput("ovf_no_valid", 64'(packet_valid), 64'd0);
    checkOutput("ovf_island_err", 64'(island_error), 64'b100);
    checkOutput("ovf_count", 64'(packet_count), 64'd18);
    send_ctrl();
    checkOutput("ovf_strobes", 64'(strobes), 64'(exp_strobes));
    send_packet(pa, 2'b00, 32, -1);
    send_ctrl();
    checkOutput("ovf_idle_strobes", 64'(strobes), 64'(exp_strobes));

    // Reset in the middle of a packet, then a fresh island
    send_guard(2'b01);
    send_guard(2'b01);
    send_packet(pg, 2'b01, 20, -1);
    reset = 1'b1;
    applyStimulus(CTRL0, CTRL0, CTRL0, 1'b0);
    reset = 1'b0;
    checkOutput("mrst_valid", 64'(packet_valid), 64'd0);
    checkOutput("mrst_header", 64'(header), 64'd0);
    checkOutput("mrst_sub1", sub[1], 64'd0);
    checkOutput("mrst_count", 64'(packet_count), 64'd0);
    checkOutput("mrst_island_err", 64'(island_error), 64'd0);
    checkOutput("mrst_sync", 64'(sync_out), 64'd0);
    send_packet(pg, 2'b01, 32, -1);
    send_ctrl();
    checkOutput("mrst_leftover_strobes", 64'(strobes), 64'(exp_strobes));
    send_guard(2'b01);
    send_guard(2'b01);
    send_packet(ph, 2'b01, 32, -1);
    exp_strobes++;
    checkOutput("mrst_new_valid", 64'(packet_valid), 64'd1);
    checkOutput("mrst_new_header", 64'(header), 64'(ph.header));
    checkOutput("mrst_new_count", 64'(packet_count), 64'd1);
    send_guard(2'b01);
    send_guard(2'b01);
    send_ctrl();
    checkOutput("mrst_new_strobes", 64'(strobes), 64'(exp_strobes));

    // Header parity bit corrupted, then a clean packet
    send_guard(2'b00);
    send_guard(2'b00);
    send_packet(pbad, 2'b00, 32, -1);
    exp_strobes++;
    checkOutput("ecc_bad_valid", 64'(packet_valid), 64'd1);
    checkOutput("ecc_bad_header", 64'(header), 64'(pbad.header));
    checkOutput("ecc_bad_flags", 64'(ecc_error), 64'(EXP_BAD_ECC));
    send_packet(ph, 2'b00, 32, -1);
    exp_strobes++;
    checkOutput("ecc_good_valid", 64'(packet_valid), 64'd1);
    checkOutput("ecc_good_flags", 64'(ecc_error), 64'd0);
    send_guard(2'b00);
    send_guard(2'b00);
    send_ctrl();
    checkOutput("ecc_strobes", 64'(strobes), 64'(exp_strobes));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
